// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall bus layout,
// stall patterns and FSM state encodings.
package pipe_stall_ctrl_pkg;

    localparam int STALL_BUS_W = 6;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    typedef logic [STALL_BUS_W-1:0] stall_bus_t;

    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_LU   = 6'b000111;
    localparam stall_bus_t STALL_MC   = 6'b001111;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MC_BUSY = 2'd1;
    localparam logic [1:0] ST_MC_DONE = 2'd2;

    // Both requests may be active at once; the stall bus is their union.
    function automatic stall_bus_t stall_merge(input logic lu_req, input logic mc_req);
        stall_bus_t lu_part;
        stall_bus_t mc_part;
        lu_part = lu_req ? STALL_LU : STALL_NONE;
        mc_part = mc_req ? STALL_MC : STALL_NONE;
        return lu_part | mc_part;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages / multi-cycle unit (master)
// and the stall controller (slave).
interface pipe_stall_ctrl_if #(
    parameter int STALL_W = pipe_stall_ctrl_pkg::STALL_BUS_W
);

    logic               stallreq_id;
    logic               stallreq_ex_mc;
    logic               mc_done;
    logic               flush_req;
    logic [STALL_W-1:0] stall;
    logic               mc_start;
    logic               mc_cancel;
    logic               mc_busy;
    logic               flush;

    modport master (
        output stallreq_id,
        output stallreq_ex_mc,
        output mc_done,
        output flush_req,
        input  stall,
        input  mc_start,
        input  mc_cancel,
        input  mc_busy,
        input  flush
    );

    modport slave (
        input  stallreq_id,
        input  stallreq_ex_mc,
        input  mc_done,
        input  flush_req,
        output stall,
        output mc_start,
        output mc_cancel,
        output mc_busy,
        output flush
    );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Load-use / multi-cycle stall cycle counters; 32-bit, wrap on overflow.
// Only built when PIPE_STALL_PERF_CNT_EN is defined.
`ifdef PIPE_STALL_PERF_CNT_EN
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_lu,
    input  logic        inc_mc,
    output logic [31:0] lu_cnt,
    output logic [31:0] mc_cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lu_cnt <= '0;
            mc_cnt <= '0;
        end else begin
            if (inc_lu) lu_cnt <= lu_cnt + 32'd1;
            if (inc_mc) mc_cnt <= mc_cnt + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges load-use and multi-cycle stall requests,
// sequences the mult/div unit. Optional perf counters: PIPE_STALL_PERF_CNT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no multi-cycle op; start one when EX requests and no flush
// MC_BUSY    | op in flight; wait for mc_done or the latency timer
// MC_DONE    | one released cycle; the finished instruction leaves EX
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int STALL_W = 6,
    parameter int MC_LAT  = 33,
    parameter int CNT_W   = 6
) (
    input  logic                clk,
    input  logic                rst,
    pipe_stall_ctrl_if.slave    bus,
    output logic [31:0]         perf_lu_cnt,
    output logic [31:0]         perf_mc_cnt
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   cnt_dec;
    logic               busy_st;
    logic               start_ok;
    logic               cancel;
    logic               mc_hold;
    logic               flush_q;
    logic [STALL_W-1:0] stall;

    // Combinational outputs are gated by rst so everything reads 0 while
    // reset is asserted, regardless of the request inputs.
    assign busy_st  = (state == ST_MC_BUSY);
    assign start_ok = rst && (state == ST_IDLE) && bus.stallreq_ex_mc && !bus.flush_req;
    assign cancel   = rst && busy_st && bus.flush_req;
    assign mc_hold  = start_ok || (rst && busy_st);
    assign stall    = STALL_W'(stall_merge(rst && bus.stallreq_id, mc_hold));
    assign cnt_dec  = cnt - CNT_W'(1);

    // The timer expires on the edge where it would reach zero, so a start
    // cycle plus MC_LAT-1 busy cycles gives MC_LAT stalled cycles in total.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_MC_BUSY;
                    cnt_nxt   = CNT_W'(MC_LAT - 1);
                end
            end
            ST_MC_BUSY: begin
                if (bus.flush_req) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (bus.mc_done || (cnt_dec == '0)) begin
                    state_nxt = ST_MC_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_dec;
                end
            end
            ST_MC_DONE: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            flush_q <= bus.flush_req;
        end
    end

    assign bus.stall     = stall;
    assign bus.mc_start  = start_ok;
    assign bus.mc_cancel = cancel;
    assign bus.mc_busy   = busy_st;
    assign bus.flush     = flush_q;

`ifdef PIPE_STALL_PERF_CNT_EN
    logic inc_lu;
    logic inc_mc;

    assign inc_lu = rst && bus.stallreq_id && !busy_st;
    assign inc_mc = stall[STG_EX];

    pipe_perf_cnt u_perf_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_lu (inc_lu),
        .inc_mc (inc_mc),
        .lu_cnt (perf_lu_cnt),
        .mc_cnt (perf_mc_cnt)
    );
`else
    assign perf_lu_cnt = '0;
    assign perf_mc_cnt = '0;
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Pipeline control block for the 5-stage core; replaces the tie-off stall generator.
- Merges the ID load-use stall request and the EX multi-cycle (mult/div) request into the shared stall bus.
- Sequences the multi-cycle unit through start, wait and completion.
- Aborts an in-flight multi-cycle operation on a pipeline flush.

Parameters:
- STALL_W, 6: stall bus width; bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
- MC_LAT, 33: maximum multi-cycle latency in cycles (≥2); acts as the fallback completion if mc_done never arrives.
- CNT_W, 6: latency counter width; must satisfy 2^CNT_W > MC_LAT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_id  in  1  load-use hazard detected in ID (combinational from ID).
- stallreq_ex_mc  in  1  EX holds a valid multi-cycle instruction.
- mc_done  in  1  multi-cycle unit result ready (single-cycle pulse).
- flush_req  in  1  branch/exception flush of the younger stages.
- stall  out  STALL_W  per-stage hold; 1 = hold the stage register.
- mc_start  out  1  single-cycle start pulse to the multi-cycle unit.
- mc_cancel  out  1  single-cycle abort pulse to the multi-cycle unit.
- mc_busy  out  1  high in MC_BUSY.
- flush  out  1  registered copy of flush_req.
- perf_lu_cnt  out  32  load-use stall cycle count.
- perf_mc_cnt  out  32  multi-cycle stall cycle count.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, cnt = 0.
  - All outputs 0, including stall = 6'b000000 and both perf counters.
- FSM states: IDLE, MC_BUSY, MC_DONE.
- IDLE:
  - On stallreq_ex_mc=1 and flush_req=0: mc_start=1 in the same cycle (combinational), and stall=6'b001111.
  - Next state MC_BUSY, cnt loaded with MC_LAT-1.
- MC_BUSY:
  - stall=6'b001111; cnt decrements each cycle.
  - On mc_done=1 or cnt==0: next state MC_DONE.
  - mc_done has priority; there is no double completion.
- MC_DONE:
  - One cycle with the multi-cycle stall released, so the instruction leaves EX at this clock edge.
  - stallreq_ex_mc is ignored in this cycle because it belongs to the same instruction.
  - Next state IDLE.
- Load-use:
  - stallreq_id=1 drives stall=6'b000111 in the same cycle, with no state change.
  - Result: one bubble into EX per asserted cycle.
- Combination: stall = OR of the load-use pattern and the multi-cycle pattern.
  - Load-use during MC_BUSY gives 6'b001111.
- Flush:
  - flush_req has priority over any start.
  - flush_req in MC_BUSY gives mc_cancel=1 that cycle and next state IDLE, with cnt cleared.
  - flush_req in IDLE blocks mc_start.
  - The flush output is flush_req delayed one cycle.
- mc_start and mc_cancel are never high in the same cycle.
- A back-to-back multi-cycle instruction starts one cycle after MC_DONE, from IDLE.
- Reset mid-operation returns to IDLE immediately; no mc_cancel is issued.

Optional Feature:
- Macro: PIPE_STALL_PERF_CNT_EN.
- Defined:
  - perf_lu_cnt increments on every cycle with stallreq_id=1 and state!=MC_BUSY.
  - perf_mc_cnt increments on every cycle with stall[3]=1.
  - Both wrap at 2^32-1 → 0 and are cleared by reset.
- Undefined: both ports remain, tied to 0, and no counter flops are generated.

Decomposition:
- Shared defines header, alongside the existing bus widths:
  - StallBus width (6) and stage bit indices.
  - The stall patterns: load-use 6'b000111, multi-cycle 6'b001111, none 6'b000000.
  - FSM state encodings: IDLE=2'd0, MC_BUSY=2'd1, MC_DONE=2'd2.
- One natural sub-module: pipe_perf_cnt, the 32-bit saturating-free wrap counter pair, instantiated only under the macro.

Test Plan:
- Reset, then hold rst=0 for 3 cycles mid-MC_BUSY → stall=0, mc_busy=0, state IDLE in the same cycle as rst falls.
- stallreq_id=1 for 1 cycle in IDLE → stall=6'b000111 that cycle only, then 0; no mc_start.
- stallreq_ex_mc=1 held, mc_done pulsed on the 5th BUSY cycle:
  - mc_start for 1 cycle, then stall=6'b001111 for 6 cycles (start + 5 BUSY).
  - Then MC_DONE with stall=0, then IDLE.
- stallreq_ex_mc=1 held, mc_done never asserted, MC_LAT=33:
  - Exit to MC_DONE after exactly 33 stalled cycles.
  - Next mc_start is 2 cycles after the last stall.
- flush_req=1 on the 3rd BUSY cycle → mc_cancel=1 that cycle, IDLE next, flush=1 one cycle later, no MC_DONE cycle.
- With PIPE_STALL_PERF_CNT_EN: 2 load-use cycles plus one 33-cycle multi-cycle op → perf_lu_cnt=2, perf_mc_cnt=33; without the macro, both read 0.
